id_pipe: RTL and testbench

ID_PIPE -- requirements
Module: id_pipe

---
 rtl/id_pipe_pkg.sv | 48 ++++
 rtl/id_decode.sv | 108 ++++++++++
 rtl/id_pipe.sv | 173 +++++++++++++++++
 tb/tb_id_pipe.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pipe_pkg.sv
// Shared opcode/funct codes, ALU-op and result-select encodings and control
// constants for the id_pipe decode stage.
package id_pipe_pkg;

    localparam logic [5:0] EXE_SPECIAL = 6'b000000;
    localparam logic [5:0] EXE_ANDI    = 6'b001100;
    localparam logic [5:0] EXE_ORI     = 6'b001101;
    localparam logic [5:0] EXE_XORI    = 6'b001110;
    localparam logic [5:0] EXE_LUI     = 6'b001111;

    localparam logic [5:0] EXE_AND = 6'b100100;
    localparam logic [5:0] EXE_OR  = 6'b100101;
    localparam logic [5:0] EXE_XOR = 6'b100110;
    localparam logic [5:0] EXE_NOR = 6'b100111;
    localparam logic [5:0] EXE_SLL = 6'b000000;
    localparam logic [5:0] EXE_SRL = 6'b000010;
    localparam logic [5:0] EXE_SRA = 6'b000011;

    localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP  = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP = 8'b0000_0011;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

    localparam logic [4:0] NOP_REG_ADDR = 5'b00000;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic READ_ENABLE   = 1'b1;
    localparam logic READ_DISABLE  = 1'b0;

    typedef struct packed {
        logic [7:0] aluop;
        logic [2:0] alusel;
        logic       re1;
        logic       re2;
        logic       wreg;
        logic       inval;
    } dec_ctrl_t;

endpackage

// File: rtl/id_decode.sv
// Combinational instruction decoder: instruction word -> ALU op/select, read
// enables, immediate/shift operand, destination index and illegal flag.
module id_decode
    import id_pipe_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
) (
    input  logic [31:0]   i_inst,
    input  logic          i_valid,
    output dec_ctrl_t     o_ctrl,
    output logic [DW-1:0] o_imm,
    output logic [RW-1:0] o_wd
);

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_sa;
    logic [15:0] w_imm16;
    logic        w_bad;

    assign w_op    = i_inst[31:26];
    assign w_rt    = i_inst[20:16];
    assign w_rd    = i_inst[15:11];
    assign w_sa    = i_inst[10:6];
    assign w_funct = i_inst[5:0];
    assign w_imm16 = i_inst[15:0];

    always_comb begin
        o_ctrl.aluop  = EXE_NOP_OP;
        o_ctrl.alusel = EXE_RES_NOP;
        o_ctrl.re1    = READ_DISABLE;
        o_ctrl.re2    = READ_DISABLE;
        o_ctrl.wreg   = WRITE_DISABLE;
        o_ctrl.inval  = 1'b0;
        o_imm         = '0;
        o_wd          = RW'(NOP_REG_ADDR);
        w_bad         = 1'b0;

        if (i_valid) begin
            case (w_op)
                EXE_ORI, EXE_ANDI, EXE_XORI, EXE_LUI: begin
                    o_ctrl.alusel = EXE_RES_LOGIC;
                    o_ctrl.re1    = READ_ENABLE;
                    o_ctrl.wreg   = WRITE_ENABLE;
                    o_wd          = RW'(w_rt);
                    o_imm         = DW'(w_imm16);
                    case (w_op)
                        EXE_ANDI: o_ctrl.aluop = EXE_AND_OP;
                        EXE_XORI: o_ctrl.aluop = EXE_XOR_OP;
                        EXE_LUI: begin
                            // LUI is rs | (imm << 16); rs is $0 in a well-formed LUI
                            o_ctrl.aluop = EXE_OR_OP;
                            o_imm        = DW'({w_imm16, 16'h0000});
                        end
                        default:  o_ctrl.aluop = EXE_OR_OP;
                    endcase
                end
                EXE_SPECIAL: begin
                    o_ctrl.re2  = READ_ENABLE;
                    o_ctrl.wreg = WRITE_ENABLE;
                    o_wd        = RW'(w_rd);
                    case (w_funct)
                        EXE_AND, EXE_OR, EXE_XOR, EXE_NOR: begin
                            o_ctrl.alusel = EXE_RES_LOGIC;
                            o_ctrl.re1    = READ_ENABLE;
                            case (w_funct)
                                EXE_AND: o_ctrl.aluop = EXE_AND_OP;
                                EXE_OR:  o_ctrl.aluop = EXE_OR_OP;
                                EXE_XOR: o_ctrl.aluop = EXE_XOR_OP;
                                default: o_ctrl.aluop = EXE_NOR_OP;
                            endcase
                        end
                        EXE_SLL, EXE_SRL, EXE_SRA: begin
                            o_ctrl.alusel = EXE_RES_SHIFT;
                            o_imm         = DW'(w_sa);
                            case (w_funct)
                                EXE_SLL: o_ctrl.aluop = EXE_SLL_OP;
                                EXE_SRL: o_ctrl.aluop = EXE_SRL_OP;
                                default: o_ctrl.aluop = EXE_SRA_OP;
                            endcase
                        end
                        default: w_bad = 1'b1;
                    endcase
                end
                default: w_bad = 1'b1;
            endcase

            if (o_wd == '0) begin
                o_ctrl.wreg = WRITE_DISABLE;
            end

            if (w_bad) begin
                o_ctrl.aluop  = EXE_NOP_OP;
                o_ctrl.alusel = EXE_RES_NOP;
                o_ctrl.re1    = READ_DISABLE;
                o_ctrl.re2    = READ_DISABLE;
                o_ctrl.wreg   = WRITE_DISABLE;
                o_ctrl.inval  = 1'b1;
                o_imm         = '0;
                o_wd          = RW'(NOP_REG_ADDR);
            end
        end
    end

endmodule

// File: rtl/id_pipe.sv
// ID stage: decode, operand bypass, hazard detection and the ID/EX register.
// Define ID_PIPE_FWD_EN for EX/MEM bypassing; otherwise pending writes stall.
module id_pipe
    import id_pipe_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32,
    parameter int unsigned RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc_i,
    input  logic [31:0]   inst_i,
    input  logic          inst_valid_i,
    input  logic [DW-1:0] reg1_data_i,
    input  logic [DW-1:0] reg2_data_i,
    output logic          reg1_read_o,
    output logic          reg2_read_o,
    output logic [RW-1:0] reg1_addr_o,
    output logic [RW-1:0] reg2_addr_o,
    input  logic          ex_wreg_i,
    input  logic [RW-1:0] ex_wd_i,
    input  logic [DW-1:0] ex_wdata_i,
    input  logic          ex_is_load_i,
    input  logic          mem_wreg_i,
    input  logic [RW-1:0] mem_wd_i,
    input  logic [DW-1:0] mem_wdata_i,
    input  logic          stall_i,
    input  logic          flush_i,
    output logic          stallreq_o,
    output logic [7:0]    ex_aluop_o,
    output logic [2:0]    ex_alusel_o,
    output logic [DW-1:0] ex_reg1_o,
    output logic [DW-1:0] ex_reg2_o,
    output logic [RW-1:0] ex_wd_o,
    output logic          ex_wreg_o,
    output logic [AW-1:0] ex_pc_o,
    output logic          ex_valid_o,
    output logic          inval_o
);

    dec_ctrl_t     w_ctrl;
    logic [DW-1:0] w_imm;
    logic [RW-1:0] w_wd;
    logic          w_dec_valid;
    logic [RW-1:0] w_rs_idx;
    logic [RW-1:0] w_rt_idx;
    logic [DW-1:0] w_op1;
    logic [DW-1:0] w_op2;
    logic          w_ex_dep;
    logic          w_mem_dep;
    logic          w_bubble;

    logic [7:0]    r_aluop;
    logic [2:0]    r_alusel;
    logic [DW-1:0] r_reg1;
    logic [DW-1:0] r_reg2;
    logic [RW-1:0] r_wd;
    logic          r_wreg;
    logic [AW-1:0] r_pc;
    logic          r_valid;
    logic          r_inval;

    // Gating decode with rst forces read enables (and thus stallreq) low in reset
    assign w_dec_valid = inst_valid_i && !rst;
    assign w_rs_idx    = RW'(inst_i[25:21]);
    assign w_rt_idx    = RW'(inst_i[20:16]);

    id_decode #(
        .DW (DW),
        .RW (RW)
    ) u_decode (
        .i_inst  (inst_i),
        .i_valid (w_dec_valid),
        .o_ctrl  (w_ctrl),
        .o_imm   (w_imm),
        .o_wd    (w_wd)
    );

    assign reg1_read_o = w_ctrl.re1;
    assign reg2_read_o = w_ctrl.re2;
    assign reg1_addr_o = rst ? '0 : w_rs_idx;
    assign reg2_addr_o = rst ? '0 : w_rt_idx;

    assign w_ex_dep  = ex_wreg_i && (ex_wd_i != '0) &&
                       ((w_ctrl.re1 && (ex_wd_i == w_rs_idx)) ||
                        (w_ctrl.re2 && (ex_wd_i == w_rt_idx)));
    assign w_mem_dep = mem_wreg_i && (mem_wd_i != '0) &&
                       ((w_ctrl.re1 && (mem_wd_i == w_rs_idx)) ||
                        (w_ctrl.re2 && (mem_wd_i == w_rt_idx)));

`ifdef ID_PIPE_FWD_EN
    logic w_unused_mem_dep;
    assign w_unused_mem_dep = w_mem_dep;
    assign stallreq_o = !rst && ex_is_load_i && w_ex_dep;
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{ex_wdata_i, mem_wdata_i, ex_is_load_i};
    assign stallreq_o = !rst && (w_ex_dep || w_mem_dep);
`endif

    always_comb begin
        w_op1 = w_imm;
        if (w_ctrl.re1) begin
            if (w_rs_idx == '0) begin
                w_op1 = '0;
`ifdef ID_PIPE_FWD_EN
            end else if (ex_wreg_i && (ex_wd_i == w_rs_idx)) begin
                w_op1 = ex_wdata_i;
            end else if (mem_wreg_i && (mem_wd_i == w_rs_idx)) begin
                w_op1 = mem_wdata_i;
`endif
            end else begin
                w_op1 = reg1_data_i;
            end
        end
    end

    always_comb begin
        w_op2 = w_imm;
        if (w_ctrl.re2) begin
            if (w_rt_idx == '0) begin
                w_op2 = '0;
`ifdef ID_PIPE_FWD_EN
            end else if (ex_wreg_i && (ex_wd_i == w_rt_idx)) begin
                w_op2 = ex_wdata_i;
            end else if (mem_wreg_i && (mem_wd_i == w_rt_idx)) begin
                w_op2 = mem_wdata_i;
`endif
            end else begin
                w_op2 = reg2_data_i;
            end
        end
    end

    // stall without a hazard holds; stall with one drops a bubble into EX
    assign w_bubble = flush_i || (stall_i && stallreq_o) || (!stall_i && !inst_valid_i);

    always_ff @(posedge clk) begin
        if (rst || w_bubble) begin
            r_aluop  <= EXE_NOP_OP;
            r_alusel <= EXE_RES_NOP;
            r_reg1   <= '0;
            r_reg2   <= '0;
            r_wd     <= RW'(NOP_REG_ADDR);
            r_wreg   <= WRITE_DISABLE;
            r_pc     <= '0;
            r_valid  <= 1'b0;
            r_inval  <= 1'b0;
        end else if (!stall_i) begin
            r_aluop  <= w_ctrl.aluop;
            r_alusel <= w_ctrl.alusel;
            r_reg1   <= w_op1;
            r_reg2   <= w_op2;
            r_wd     <= w_wd;
            r_wreg   <= w_ctrl.wreg;
            r_pc     <= pc_i;
            r_valid  <= 1'b1;
            r_inval  <= w_ctrl.inval;
        end
    end

    assign ex_aluop_o  = r_aluop;
    assign ex_alusel_o = r_alusel;
    assign ex_reg1_o   = r_reg1;
    assign ex_reg2_o   = r_reg2;
    assign ex_wd_o     = r_wd;
    assign ex_wreg_o   = r_wreg;
    assign ex_pc_o     = r_pc;
    assign ex_valid_o  = r_valid;
    assign inval_o     = r_inval;

endmodule

// File: tb/tb_id_pipe.sv
// Self-checking bench for id_pipe: directed scenarios plus randomized traffic
// against an instruction-level reference model.
module tb_id_pipe;

    typedef struct packed {
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] pc;
        logic        valid;
        logic        inval;
    } idex_t;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic        inst_valid_i;
    logic [31:0] reg1_data_i;
    logic [31:0] reg2_data_i;
    logic        reg1_read_o;
    logic        reg2_read_o;
    logic [4:0]  reg1_addr_o;
    logic [4:0]  reg2_addr_o;
    logic        ex_wreg_i;
    logic [4:0]  ex_wd_i;
    logic [31:0] ex_wdata_i;
    logic        ex_is_load_i;
    logic        mem_wreg_i;
    logic [4:0]  mem_wd_i;
    logic [31:0] mem_wdata_i;
    logic        stall_i;
    logic        flush_i;
    logic        stallreq_o;
    logic [7:0]  ex_aluop_o;
    logic [2:0]  ex_alusel_o;
    logic [31:0] ex_reg1_o;
    logic [31:0] ex_reg2_o;
    logic [4:0]  ex_wd_o;
    logic        ex_wreg_o;
    logic [31:0] ex_pc_o;
    logic        ex_valid_o;
    logic        inval_o;

    logic [31:0] rf [32];
    idex_t       obs;
    idex_t       exp_q;
    int          checks;
    int          errors;

    id_pipe dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .inst_i       (inst_i),
        .inst_valid_i (inst_valid_i),
        .reg1_data_i  (reg1_data_i),
        .reg2_data_i  (reg2_data_i),
        .reg1_read_o  (reg1_read_o),
        .reg2_read_o  (reg2_read_o),
        .reg1_addr_o  (reg1_addr_o),
        .reg2_addr_o  (reg2_addr_o),
        .ex_wreg_i    (ex_wreg_i),
        .ex_wd_i      (ex_wd_i),
        .ex_wdata_i   (ex_wdata_i),
        .ex_is_load_i (ex_is_load_i),
        .mem_wreg_i   (mem_wreg_i),
        .mem_wd_i     (mem_wd_i),
        .mem_wdata_i  (mem_wdata_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .stallreq_o   (stallreq_o),
        .ex_aluop_o   (ex_aluop_o),
        .ex_alusel_o  (ex_alusel_o),
        .ex_reg1_o    (ex_reg1_o),
        .ex_reg2_o    (ex_reg2_o),
        .ex_wd_o      (ex_wd_o),
        .ex_wreg_o    (ex_wreg_o),
        .ex_pc_o      (ex_pc_o),
        .ex_valid_o   (ex_valid_o),
        .inval_o      (inval_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb reg1_data_i = rf[reg1_addr_o];
    always_comb reg2_data_i = rf[reg2_addr_o];
    always_comb obs = {ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o,
                       ex_pc_o, ex_valid_o, inval_o};

    // kinds: 0 ORI 1 ANDI 2 XORI 3 LUI 4 AND 5 OR 6 XOR 7 NOR 8 SLL 9 SRL 10 SRA 11 illegal
    function automatic logic [31:0] mk_inst(input int kind, input logic [4:0] rs, rt, rd,
                                            input logic [15:0] imm, input logic [4:0] sa);
        case (kind)
            0:       return {6'h0d, rs, rt, imm};
            1:       return {6'h0c, rs, rt, imm};
            2:       return {6'h0e, rs, rt, imm};
            3:       return {6'h0f, 5'd0, rt, imm};
            4:       return {6'h00, rs, rt, rd, 5'd0, 6'h24};
            5:       return {6'h00, rs, rt, rd, 5'd0, 6'h25};
            6:       return {6'h00, rs, rt, rd, 5'd0, 6'h26};
            7:       return {6'h00, rs, rt, rd, 5'd0, 6'h27};
            8:       return {6'h00, 5'd0, rt, rd, sa, 6'h00};
            9:       return {6'h00, 5'd0, rt, rd, sa, 6'h02};
            10:      return {6'h00, 5'd0, rt, rd, sa, 6'h03};
            default: return {6'h3f, rs, rt, imm};
        endcase
    endfunction

    function automatic logic [31:0] res(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
`ifdef ID_PIPE_FWD_EN
        if (ex_wreg_i && ex_wd_i == idx) return ex_wdata_i;
        if (mem_wreg_i && mem_wd_i == idx) return mem_wdata_i;
`endif
        return rf[idx];
    endfunction

    function automatic logic hazard(input logic u1, input logic [4:0] i1,
                                    input logic u2, input logic [4:0] i2);
        logic exm;
        logic memm;
        exm  = ex_wreg_i && ex_wd_i != 0 && ((u1 && ex_wd_i == i1) || (u2 && ex_wd_i == i2));
        memm = mem_wreg_i && mem_wd_i != 0 && ((u1 && mem_wd_i == i1) || (u2 && mem_wd_i == i2));
`ifdef ID_PIPE_FWD_EN
        return exm && ex_is_load_i;
`else
        return exm || memm;
`endif
    endfunction

    function automatic void ref_decode(input int kind, input logic [4:0] rs, rt, rd,
                                       input logic [15:0] imm, input logic [4:0] sa,
                                       input logic [31:0] pc, output idex_t e,
                                       output logic u1, output logic u2);
        e = '0;
        e.valid = 1'b1;
        e.pc = pc;
        u1 = 1'b0;
        u2 = 1'b0;
        if (kind <= 3) begin
            u1 = 1'b1;
            e.alusel = 3'b001;
            e.wd = rt;
            e.wreg = (rt != 0);
            e.r1 = res(rs);
            e.r2 = (kind == 3) ? {imm, 16'h0} : {16'h0, imm};
            e.aluop = (kind == 1) ? 8'h24 : (kind == 2) ? 8'h26 : 8'h25;
        end else if (kind <= 7) begin
            u1 = 1'b1;
            u2 = 1'b1;
            e.alusel = 3'b001;
            e.wd = rd;
            e.wreg = (rd != 0);
            e.r1 = res(rs);
            e.r2 = res(rt);
            e.aluop = 8'h24 + 8'(kind - 4);
        end else if (kind <= 10) begin
            u2 = 1'b1;
            e.alusel = 3'b010;
            e.wd = rd;
            e.wreg = (rd != 0);
            e.r1 = {27'h0, sa};
            e.r2 = res(rt);
            e.aluop = (kind == 8) ? 8'h7c : (kind == 9) ? 8'h02 : 8'h03;
        end else begin
            e.inval = 1'b1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        inst_i = 32'h0; inst_valid_i = 1'b0; pc_i = 32'h0;
        ex_wreg_i = 1'b0; ex_wd_i = 5'd0; ex_wdata_i = 32'h0; ex_is_load_i = 1'b0;
        mem_wreg_i = 1'b0; mem_wd_i = 5'd0; mem_wdata_i = 32'h0;
        stall_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic set_inst(input logic [31:0] inst, input logic [31:0] pc);
        inst_i = inst; inst_valid_i = 1'b1; pc_i = pc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        set_inst({6'h0c, 5'd4, 5'd5, 16'h00ff}, 32'h40);
        ex_wreg_i = 1'b1; ex_wd_i = 5'd4; ex_is_load_i = 1'b1;
        tick();
        tick();
        checks++;
        if (obs !== '0) begin
            errors++; $display("FAIL reset_outputs got %h exp 0", obs);
        end
        checks++;
        if (stallreq_o !== 1'b0) begin
            errors++; $display("FAIL reset_stallreq got %b exp 0", stallreq_o);
        end
        checks++;
        if ({reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o} !== 12'h0) begin
            errors++; $display("FAIL reset_rf_port got %b%b %0d %0d exp 0", reg1_read_o,
                               reg2_read_o, reg1_addr_o, reg2_addr_o);
        end
        rst = 1'b0;
        set_idle();
    endtask

    task automatic test_ori();
        set_idle();
        set_inst({6'h0d, 5'd0, 5'd1, 16'h1100}, 32'h100);
        tick();
        checks++;
        if ({ex_reg1_o, ex_reg2_o} !== {32'h0, 32'h00001100}) begin
            errors++; $display("FAIL ori_operands got %h %h exp 0 00001100", ex_reg1_o, ex_reg2_o);
        end
        checks++;
        if ({ex_wd_o, ex_wreg_o, ex_aluop_o, ex_alusel_o, ex_valid_o, ex_pc_o} !==
            {5'd1, 1'b1, 8'h25, 3'b001, 1'b1, 32'h100}) begin
            errors++; $display("FAIL ori_ctrl got wd %0d wreg %b op %h sel %h v %b pc %h",
                               ex_wd_o, ex_wreg_o, ex_aluop_o, ex_alusel_o, ex_valid_o, ex_pc_o);
        end
    endtask

    task automatic test_forward();
        logic        exp_sr;
        logic [31:0] exp1;
        logic [31:0] exp2;
        set_idle();
        set_inst({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h25}, 32'h104);
        ex_wreg_i = 1'b1; ex_wd_i = 5'd1; ex_wdata_i = 32'hAAAA0000;
        mem_wreg_i = 1'b1; mem_wd_i = 5'd2; mem_wdata_i = 32'h0000BBBB;
`ifdef ID_PIPE_FWD_EN
        exp_sr = 1'b0; exp1 = 32'hAAAA0000; exp2 = 32'h0000BBBB;
`else
        exp_sr = 1'b1; exp1 = rf[1]; exp2 = rf[2];
`endif
        #1;
        checks++;
        if (stallreq_o !== exp_sr) begin
            errors++; $display("FAIL fwd_stallreq got %b exp %b", stallreq_o, exp_sr);
        end
        tick();
        checks++;
        if ({ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o} !== {exp1, exp2, 5'd3, 1'b1}) begin
            errors++; $display("FAIL fwd_operands got %h %h wd %0d exp %h %h wd 3", ex_reg1_o,
                               ex_reg2_o, ex_wd_o, exp1, exp2);
        end
    endtask

    task automatic test_load_use();
        set_idle();
        set_inst({6'h0d, 5'd0, 5'd9, 16'h0042}, 32'h108);
        tick();
        set_inst({6'h0c, 5'd4, 5'd5, 16'h00ff}, 32'h10c);
        ex_wreg_i = 1'b1; ex_wd_i = 5'd4; ex_is_load_i = 1'b1; ex_wdata_i = 32'h12345678;
        stall_i = 1'b1;
        #1;
        checks++;
        if (stallreq_o !== 1'b1) begin
            errors++; $display("FAIL loaduse_stallreq got %b exp 1", stallreq_o);
        end
        tick();
        checks++;
        if (obs !== '0) begin
            errors++; $display("FAIL loaduse_bubble got %h exp 0", obs);
        end
        ex_wreg_i = 1'b0; ex_is_load_i = 1'b0; stall_i = 1'b0;
        #1;
        checks++;
        if (stallreq_o !== 1'b0) begin
            errors++; $display("FAIL loaduse_release got %b exp 0", stallreq_o);
        end
        tick();
        checks++;
        if ({ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o, ex_aluop_o, ex_valid_o, ex_pc_o} !==
            {rf[4], 32'h000000ff, 5'd5, 1'b1, 8'h24, 1'b1, 32'h10c}) begin
            errors++; $display("FAIL loaduse_andi got %h %h wd %0d op %h v %b exp %h 000000ff wd 5",
                               ex_reg1_o, ex_reg2_o, ex_wd_o, ex_aluop_o, ex_valid_o, rf[4]);
        end
    endtask

    task automatic test_flush_stall();
        set_idle();
        set_inst({6'h0d, 5'd0, 5'd2, 16'h0007}, 32'h110);
        tick();
        checks++;
        if (ex_valid_o !== 1'b1) begin
            errors++; $display("FAIL flush_pre_valid got %b exp 1", ex_valid_o);
        end
        set_inst({6'h0f, 5'd0, 5'd7, 16'h1234}, 32'h114);
        flush_i = 1'b1; stall_i = 1'b1;
        tick();
        checks++;
        if (obs !== '0) begin
            errors++; $display("FAIL flush_bubble got %h exp 0", obs);
        end
        flush_i = 1'b0; stall_i = 1'b0;
        tick();
        checks++;
        if ({ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o, ex_aluop_o} !==
            {32'h0, 32'h12340000, 5'd7, 1'b1, 8'h25}) begin
            errors++; $display("FAIL lui_load got %h %h wd %0d wreg %b op %h exp 0 12340000 7 1 25",
                               ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o, ex_aluop_o);
        end
    endtask

    task automatic test_inval();
        set_idle();
        set_inst({6'h3f, 26'($urandom)}, 32'h120);
        tick();
        checks++;
        if ({inval_o, ex_wreg_o, ex_aluop_o, ex_valid_o} !== {1'b1, 1'b0, 8'h00, 1'b1}) begin
            errors++; $display("FAIL inval_op got inval %b wreg %b op %h v %b exp 1 0 00 1",
                               inval_o, ex_wreg_o, ex_aluop_o, ex_valid_o);
        end
        set_inst({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h3f}, 32'h124);
        tick();
        checks++;
        if ({inval_o, ex_wreg_o, ex_aluop_o} !== {1'b1, 1'b0, 8'h00}) begin
            errors++; $display("FAIL inval_funct got inval %b wreg %b op %h exp 1 0 00",
                               inval_o, ex_wreg_o, ex_aluop_o);
        end
        set_inst({6'h0d, 5'd0, 5'd0, 16'h0005}, 32'h128);
        tick();
        checks++;
        if ({inval_o, ex_wreg_o, ex_aluop_o, ex_reg2_o} !== {1'b0, 1'b0, 8'h25, 32'h5}) begin
            errors++; $display("FAIL ori_r0 got inval %b wreg %b op %h r2 %h exp 0 0 25 5",
                               inval_o, ex_wreg_o, ex_aluop_o, ex_reg2_o);
        end
    endtask

    task automatic test_reset_mid_stall();
        set_idle();
        set_inst({6'h0d, 5'd0, 5'd2, 16'h0007}, 32'h130);
        tick();
        set_inst({6'h0d, 5'd0, 5'd3, 16'h0009}, 32'h134);
        stall_i = 1'b1;
        tick();
        checks++;
        if ({ex_wd_o, ex_reg2_o, ex_pc_o} !== {5'd2, 32'h7, 32'h130}) begin
            errors++; $display("FAIL stall_hold got wd %0d r2 %h pc %h exp 2 7 130", ex_wd_o,
                               ex_reg2_o, ex_pc_o);
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs !== '0 || stallreq_o !== 1'b0 || reg1_addr_o !== 5'd0) begin
                errors++; $display("FAIL rst_in_stall cyc %0d got %h sr %b a1 %0d exp 0", i, obs,
                                   stallreq_o, reg1_addr_o);
            end
        end
        rst = 1'b0;
        stall_i = 1'b0;
        set_inst({6'h0d, 5'd0, 5'd6, 16'h0055}, 32'h200);
        tick();
        checks++;
        if ({ex_reg2_o, ex_wd_o, ex_wreg_o, ex_valid_o, ex_pc_o} !==
            {32'h55, 5'd6, 1'b1, 1'b1, 32'h200}) begin
            errors++; $display("FAIL post_reset_ori got r2 %h wd %0d wreg %b v %b pc %h",
                               ex_reg2_o, ex_wd_o, ex_wreg_o, ex_valid_o, ex_pc_o);
        end
    endtask

    task automatic test_random();
        idex_t e;
        logic  u1;
        logic  u2;
        logic  hz;
        set_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q = '0;
        for (int n = 0; n < 400; n++) begin
            int          kind;
            logic [4:0]  rs;
            logic [4:0]  rt;
            logic [4:0]  rd;
            logic [4:0]  sa;
            logic [15:0] imm;
            logic        vld;
            kind = int'($urandom_range(0, 11));
            rs = 5'($urandom_range(0, 7));
            rt = 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7));
            sa = 5'($urandom);
            imm = 16'($urandom);
            if (kind == 3 || (kind >= 8 && kind <= 10)) rs = 5'd0;
            vld = ($urandom_range(0, 7) != 0);
            inst_i = mk_inst(kind, rs, rt, rd, imm, sa);
            inst_valid_i = vld;
            pc_i = $urandom;
            ex_wreg_i = 1'($urandom_range(0, 1));
            ex_wd_i = 5'($urandom_range(0, 7));
            ex_wdata_i = $urandom;
            ex_is_load_i = ($urandom_range(0, 3) == 0);
            mem_wreg_i = 1'($urandom_range(0, 1));
            mem_wd_i = 5'($urandom_range(0, 7));
            mem_wdata_i = $urandom;
            stall_i = ($urandom_range(0, 4) == 0);
            flush_i = ($urandom_range(0, 9) == 0);
            ref_decode(kind, rs, rt, rd, imm, sa, pc_i, e, u1, u2);
            hz = vld && hazard(u1, rs, u2, rt);
            #1;
            checks++;
            if (stallreq_o !== hz) begin
                errors++; $display("FAIL rand_stallreq n %0d kind %0d got %b exp %b", n, kind,
                                   stallreq_o, hz);
            end
            checks++;
            if ({reg1_read_o, reg2_read_o} !== {vld && u1, vld && u2}) begin
                errors++; $display("FAIL rand_read_en n %0d kind %0d got %b%b exp %b%b", n, kind,
                                   reg1_read_o, reg2_read_o, vld && u1, vld && u2);
            end
            if (flush_i || (stall_i && hz) || (!stall_i && !vld)) exp_q = '0;
            else if (!stall_i) exp_q = e;
            tick();
            checks++;
            if (obs !== exp_q) begin
                errors++; $display("FAIL rand_idex n %0d kind %0d got %h exp %h", n, kind, obs,
                                   exp_q);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) rf[i] = $urandom | 32'h1;
        test_reset();
        test_ori();
        test_forward();
        test_load_use();
        test_flush_stall();
        test_inval();
        test_reset_mid_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
